// File: rtl/dest_value_arbiter.sv
// Destination-value arbiter: N_CH functional-unit result channels share one registered writeback port.
// Optional macro DEST_ARB_ROUND_ROBIN_EN: rotating priority pointer instead of fixed lowest-index priority.
module dest_value_arbiter #(
    parameter int N_CH   = 3,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int SRC_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        ch_valid,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [N_CH*TAG_W-1:0]  ch_tag,
    output logic [N_CH-1:0]        ch_ready,
    output logic                   wb_valid,
    output logic [DATA_W-1:0]      wb_data,
    output logic [TAG_W-1:0]       wb_tag,
    output logic [SRC_W-1:0]       wb_src,
    input  logic                   wb_ready,
    output logic [15:0]            conflict_cnt
);

    logic              wbValid_q, wbValid_d;
    logic [DATA_W-1:0] wbData_q, wbData_d;
    logic [TAG_W-1:0]  wbTag_q, wbTag_d;
    logic [SRC_W-1:0]  wbSrc_q, wbSrc_d;
    logic [15:0]       conflictCnt_q, conflictCnt_d;

    logic              loadEn;
    logic              anyValid;
    logic              conflict;
    logic [SRC_W-1:0]  grantIdx;
    logic [DATA_W-1:0] selData;
    logic [TAG_W-1:0]  selTag;

    assign loadEn   = rst_n & (~wbValid_q | wb_ready);
    assign anyValid = |ch_valid;
    // Two or more bits set: clearing the lowest set bit still leaves something.
    assign conflict = (ch_valid & (ch_valid - N_CH'(1))) != '0;

`ifdef DEST_ARB_ROUND_ROBIN_EN
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [N_CH-1:0]  rotValid;
    logic             found;
    int               rrIdx;

    // Rotate so bit k of rotValid is channel (ptr+k) mod N_CH.
    assign rotValid = N_CH'({ch_valid, ch_valid} >> ptr_q);

    always_comb begin
        grantIdx = '0;
        found    = 1'b0;
        rrIdx    = 0;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && rotValid[k]) begin
                found = 1'b1;
                rrIdx = int'(ptr_q) + k;
                if (rrIdx >= N_CH) begin
                    rrIdx = rrIdx - N_CH;
                end
                grantIdx = SRC_W'(rrIdx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (loadEn && anyValid) begin
            ptr_d = (grantIdx == SRC_W'(N_CH - 1)) ? '0 : grantIdx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grantIdx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_valid[i]) begin
                grantIdx = SRC_W'(i);
            end
        end
    end
`endif

    assign ch_ready = (loadEn && anyValid) ? (N_CH'(1) << grantIdx) : '0;

    always_comb begin
        selData = '0;
        selTag  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grantIdx == SRC_W'(i)) begin
                selData = ch_data[i*DATA_W +: DATA_W];
                selTag  = ch_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // Payload only moves on a real transfer so it holds through stalls and idle loads.
    always_comb begin
        wbValid_d     = wbValid_q;
        wbData_d      = wbData_q;
        wbTag_d       = wbTag_q;
        wbSrc_d       = wbSrc_q;
        conflictCnt_d = conflictCnt_q;
        if (conflict && conflictCnt_q != 16'hFFFF) begin
            conflictCnt_d = conflictCnt_q + 16'd1;
        end
        if (loadEn) begin
            wbValid_d = anyValid;
            if (anyValid) begin
                wbData_d = selData;
                wbTag_d  = selTag;
                wbSrc_d  = grantIdx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbValid_q     <= 1'b0;
            wbData_q      <= '0;
            wbTag_q       <= '0;
            wbSrc_q       <= '0;
            conflictCnt_q <= '0;
        end else begin
            wbValid_q     <= wbValid_d;
            wbData_q      <= wbData_d;
            wbTag_q       <= wbTag_d;
            wbSrc_q       <= wbSrc_d;
            conflictCnt_q <= conflictCnt_d;
        end
    end

    assign wb_valid     = wbValid_q;
    assign wb_data      = wbData_q;
    assign wb_tag       = wbTag_q;
    assign wb_src       = wbSrc_q;
    assign conflict_cnt = conflictCnt_q;

endmodule
